async_event_arbiter: RTL
========================

// Module: async_event_arbiter
// PURPOSE
// - Collects one-cycle event pulses from N async_trap_and_reset_oneshot channels (their out_sync_sig), already
//   synchronised to outclk.
// - Queues one pending event per channel and serialises them to a single consumer over a valid/ready handshake,
//   using round-robin priority.
// - Drives each channel's auto_reset input. A channel's trap stays held while its event waits, then re-arms after service.
// PARAMETERS
// - N_CH         4   number of one-shot channels (2..16)
// - COOL_CYCLES  2   idle cycles after each accepted event before the next grant (0..15; 0 = back-to-back grants)
// - DROP_W       8   width of the saturating drop counter
// PORTS
// - outclk                  in   1                 system clock; all state changes on posedge
// - actual_async_sig_reset  in   1                 reset, asynchronous, active-high
// - evt_pulse               in   N_CH              out_sync_sig from each one-shot; 1-cycle pulses
// - ch_enable               in   N_CH              per-channel enable; a disabled channel ignores pulses and never
//                                                  becomes pending
// - auto_reset_o            out  N_CH              to each one-shot's auto_reset; = ch_enable[i] & ~pending[i] (combinational)
// - evt_valid               out  1                 event offered to the consumer
// - evt_id                  out  $clog2(N_CH)      channel index of the offered event
// - evt_ready               in   1                 consumer accepts when evt_valid & evt_ready at a posedge
// - drop_flag               out  N_CH              sticky; set when a pulse arrives while that channel is already pending
// - drop_cnt                out  DROP_W            saturating count of all drops
// - clr_stats               in   1                 synchronous clear of drop_flag and drop_cnt
// BEHAVIOUR
// - Reset values (asynchronous):
//   - pending = 0, state = IDLE, evt_valid = 0, evt_id = 0, drop_flag = 0, drop_cnt = 0
//   - last_grant = N_CH-1, so ch0 has first priority.
// - pending[i]:
//   - Set at the posedge where evt_pulse[i] & ch_enable[i].
//   - Cleared at the posedge where channel i's event is accepted.
//   - Pulse and accept on the same channel in the same cycle: pending stays 1. This is a new event, not a drop.
// - Drop: pulse & ch_enable while pending[i]=1 and not being accepted that cycle.
//   - Sets drop_flag[i].
//   - drop_cnt += number of dropping channels that cycle, saturating at 2^DROP_W-1.
// - clr_stats has priority over new drops in the same cycle; drops in that cycle are lost.
// - Disabling ch_enable[i] does not clear an existing pending[i]; that event is still delivered.
// - FSM IDLE -> GRANT -> COOL -> IDLE:
//   - IDLE: if any pending, pick the first pending channel after last_grant (wrapping modulo N_CH).
//     Register evt_id and last_grant, assert evt_valid, go to GRANT.
//   - GRANT: evt_valid=1. evt_id is stable until accepted.
//     On evt_valid & evt_ready: evt_valid=0 next cycle and pending[evt_id] clears.
//     Then go to COOL, or straight to IDLE if COOL_CYCLES=0.
//   - COOL: a 4-bit counter loaded with COOL_CYCLES-1 counts down; at 0, go to IDLE. evt_valid stays 0.
// - Latency: with the FSM in IDLE, a pulse sampled at edge t sets pending at t and evt_valid at edge t+1.
//   Minimum spacing between accepts is COOL_CYCLES+2 cycles.
// - A valid is never withdrawn before it is accepted. The consumer may hold evt_ready high permanently.
// - Reset mid-GRANT: evt_valid drops immediately (async) and all pending events are discarded.
// - auto_reset_o low while pending holds the trap set, so further edges on that channel are merged, not re-pulsed.
//   After accept, auto_reset_o rises combinationally and the one-shot clears itself.
// TESTING
// - Reset, then a single pulse on ch2 with evt_ready=1
//   -> evt_valid=1, evt_id=2 exactly one cycle after pending sets; pending[2]=0 after accept; auto_reset_o[2]=1.
// - Pulses on ch0, ch1, ch3 in the same cycle, evt_ready=1, COOL_CYCLES=2
//   -> grants in order 0, 1, 3; accepts 4 cycles apart.
// - Round-robin fairness: last_grant=1, ch0 and ch3 both pending -> ch3 granted first, then ch0.
// - evt_ready=0 for 10 cycles with ch1 pending, plus a second ch1 pulse
//   -> evt_valid and evt_id=1 stable; drop_flag[1]=1, drop_cnt=1; clr_stats -> both return to 0.
// - Saturation, DROP_W=2: 5 drops -> drop_cnt=3.
// - ch_enable[0]=0 with a pulse on ch0 -> no pending, no drop, auto_reset_o[0]=0.
// - Assert reset during GRANT -> evt_valid=0 within the same cycle; after release no stale grant; a new pulse is served normally.

Source files
------------

// File: rtl/async_event_arbiter.sv
// rtl/async_event_arbiter.sv - round-robin serialiser of one-shot channel events with drop statistics
module async_event_arbiter #(
    parameter int N_CH        = 4,
    parameter int COOL_CYCLES = 2,
    parameter int DROP_W      = 8
) (
    input  logic                    outclk,
    input  logic                    actual_async_sig_reset,
    input  logic [N_CH-1:0]         evt_pulse,
    input  logic [N_CH-1:0]         ch_enable,
    output logic [N_CH-1:0]         auto_reset_o,
    output logic                    evt_valid,
    output logic [$clog2(N_CH)-1:0] evt_id,
    input  logic                    evt_ready,
    output logic [N_CH-1:0]         drop_flag,
    output logic [DROP_W-1:0]       drop_cnt,
    input  logic                    clr_stats
);

    localparam int ID_W  = $clog2(N_CH);
    localparam int SUM_W = DROP_W + 5;

    // Cool-down counter starts one below the idle count so that the
    // total accept-to-accept spacing is COOL_CYCLES + 2.
    localparam logic [3:0] COOL_LOAD = (COOL_CYCLES > 0) ? 4'(COOL_CYCLES - 1) : 4'd0;
    localparam logic [SUM_W-1:0] CNT_MAX = {{5{1'b0}}, {DROP_W{1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_COOL  = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [N_CH-1:0]   pending;
    logic [ID_W-1:0]   last_grant;
    logic [3:0]        cool_cnt;

    logic              accept;
    logic [N_CH-1:0]   acc_vec;
    logic [N_CH-1:0]   new_evt;
    logic [N_CH-1:0]   drops;
    logic [4:0]        n_drop;
    logic [SUM_W-1:0]  sum_cnt;

    logic              pick_found;
    logic [ID_W-1:0]   pick_id;
    logic [ID_W-1:0]   cand_id;

    // evt_valid is exactly "in GRANT", so accept needs only evt_ready there.
    assign accept  = (state == S_GRANT) & evt_ready;
    assign acc_vec = accept ? (N_CH'(1) << evt_id) : '0;
    assign new_evt = evt_pulse & ch_enable;
    // A pulse landing on the channel being accepted is a fresh event, not a drop.
    assign drops   = new_evt & pending & ~acc_vec;
    assign n_drop  = 5'($countones(drops));
    assign sum_cnt = SUM_W'(drop_cnt) + SUM_W'(n_drop);

    // Round-robin pick: first pending channel strictly after last_grant, wrapping.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        cand_id    = '0;
        for (int k = 1; k <= N_CH; k++) begin
            cand_id = ID_W'((int'(last_grant) + k) % N_CH);
            if (!pick_found && pending[cand_id]) begin
                pick_found = 1'b1;
                pick_id    = cand_id;
            end
        end
    end

    // FSM state register; reset drops out of GRANT immediately.
    always_ff @(posedge outclk or posedge actual_async_sig_reset) begin
        if (actual_async_sig_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state: IDLE -> GRANT -> (COOL ->) IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (pick_found) begin
                    state_nxt = S_GRANT;
                end
            end
            S_GRANT: begin
                if (evt_ready) begin
                    state_nxt = (COOL_CYCLES == 0) ? S_IDLE : S_COOL;
                end
            end
            S_COOL: begin
                if (cool_cnt == 4'd0) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // FSM outputs: offer while in GRANT; release a trap only when nothing is queued for it.
    always_comb begin
        evt_valid    = (state == S_GRANT);
        auto_reset_o = ch_enable & ~pending;
    end

    // Grant bookkeeping: offered id, round-robin pointer and cool-down counter.
    always_ff @(posedge outclk or posedge actual_async_sig_reset) begin
        if (actual_async_sig_reset) begin
            evt_id     <= '0;
            last_grant <= ID_W'(N_CH - 1);
            cool_cnt   <= 4'd0;
        end else begin
            if (state == S_IDLE && pick_found) begin
                evt_id     <= pick_id;
                last_grant <= pick_id;
            end
            if (accept) begin
                cool_cnt <= COOL_LOAD;
            end else if (state == S_COOL && cool_cnt != 4'd0) begin
                cool_cnt <= cool_cnt - 4'd1;
            end
        end
    end

    // Pending set: new enabled pulses set, accepted channel clears, set wins on collision.
    always_ff @(posedge outclk or posedge actual_async_sig_reset) begin
        if (actual_async_sig_reset) begin
            pending <= '0;
        end else begin
            pending <= (pending & ~acc_vec) | new_evt;
        end
    end

    // Drop statistics: sticky per-channel flags and a saturating total; clear wins.
    always_ff @(posedge outclk or posedge actual_async_sig_reset) begin
        if (actual_async_sig_reset) begin
            drop_flag <= '0;
            drop_cnt  <= '0;
        end else if (clr_stats) begin
            drop_flag <= '0;
            drop_cnt  <= '0;
        end else begin
            drop_flag <= drop_flag | drops;
            drop_cnt  <= (sum_cnt > CNT_MAX) ? {DROP_W{1'b1}} : sum_cnt[DROP_W-1:0];
        end
    end

endmodule
